booth_mul_arbiter: RTL and testbench

- Round-robin scheduler sharing one booth_multiplier instance among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready, issues one operation at a time to the multiplier and waits for its valid_out.
- Returns the product to the originating requester over a per-requester response handshake.
- Sits between client blocks (filters, accumulators) and the multi-cycle multiplier.

---
 rtl/booth_mul_arbiter.sv | 166 ++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Round-robin scheduler that shares one multi-cycle booth multiplier among
//   NUM_REQ requesters. One operation is in flight at a time; the product is
//   returned to the requester that issued it.
//
// Ports
//   clk            clock, all state on the rising edge
//   reset          asynchronous active-low reset
//   req_valid      per-requester request valid
//   req_ready      per-requester accept, one-hot or zero
//   req_a, req_b   packed operands, requester i at [i*WIDTH_IN +: WIDTH_IN]
//   rsp_valid      per-requester response valid, one-hot or zero
//   rsp_ready      per-requester response accept
//   rsp_product    shared product bus, qualified by rsp_valid
//   rsp_error      watchdog timeout flag, qualified by rsp_valid
//   mul_a, mul_b   multiplier operands, stable from ISSUE until WAIT exits
//   mul_valid_in   multiplier start pulse
//   mul_valid_out  multiplier done
//   mul_product    multiplier result
//   busy           high whenever the FSM is not in IDLE
//
// Build option
//   BOOTH_ARB_TIMEOUT_EN  adds a WAIT watchdog of TIMEOUT_CYCLES cycles that
//                         returns rsp_product=0, rsp_error=1. Without it WAIT
//                         waits forever and rsp_error is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | searching for the next requester; accepts in the same cycle
// ISSUE | one-cycle start pulse to the multiplier
// WAIT  | waiting for mul_valid_out (or the watchdog, if built in)
// RESP  | holding the response until the granted requester accepts it

module booth_mul_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH_IN       = 16,
  parameter int WIDTH_PRODUCT  = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [WIDTH_PRODUCT-1:0]     rsp_product,
  output logic                         rsp_error,
  output logic [WIDTH_IN-1:0]          mul_a,
  output logic [WIDTH_IN-1:0]          mul_b,
  output logic                         mul_valid_in,
  input  logic                         mul_valid_out,
  input  logic [WIDTH_PRODUCT-1:0]     mul_product,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("booth_mul_arbiter: parameter out of range");
  end

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] search_idx;
  logic             search_hit;
  logic             timed_out;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    search_hit = 1'b0;
    search_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!search_hit && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        search_hit = 1'b1;
        search_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // req_ready is combinational; gating with reset keeps it low while reset
  // is held even if requesters keep their valids up.
  assign req_ready    = (state == S_IDLE && search_hit && reset)
                        ? (NUM_REQ'(1) << search_idx) : '0;
  assign rsp_valid    = (state == S_RESP) ? (NUM_REQ'(1) << grant) : '0;
  assign mul_valid_in = (state == S_ISSUE);
  assign busy         = (state != S_IDLE);

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt counts completed WAIT cycles; the last permitted one times out.
  assign timed_out = (state == S_WAIT) && !mul_valid_out &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (mul_valid_out) begin
          rsp_error <= 1'b0;
        end else if (timed_out) begin
          rsp_error <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`else
  assign timed_out = 1'b0;
  assign rsp_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      grant       <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (search_hit) begin
            grant <= search_idx;
            mul_a <= req_a[search_idx*WIDTH_IN +: WIDTH_IN];
            mul_b <= req_b[search_idx*WIDTH_IN +: WIDTH_IN];
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mul_valid_out) begin
            rsp_product <= mul_product;
            state       <= S_RESP;
          end else if (timed_out) begin
            rsp_product <= '0;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[grant]) begin
            ptr   <= grant;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int P  = 32;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [P-1:0]   rsp_product;
  logic           rsp_error;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_valid_in;
  logic           mul_valid_out = 1'b0;
  logic [P-1:0]   mul_product = '0;
  logic           busy;

  always #5 clk = ~clk;

  booth_mul_arbiter #(
    .NUM_REQ(N), .WIDTH_IN(W), .WIDTH_PRODUCT(P), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_error(rsp_error),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid_in(mul_valid_in), .mul_valid_out(mul_valid_out),
    .mul_product(mul_product), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: pending requests and round-robin pointer.
  bit         pend [N];
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  int         mptr;

  // Multiplier stub (environment): fixed latency, optional hang, spurious pulse.
  int          stub_lat = 1;
  bit          stub_hang = 1'b0;
  int          stub_cnt = 0;
  int          cyc_n = 0;
  int          spur_cycle = -1;
  logic [P-1:0] stub_res = '0;

  always begin
    @(posedge clk);
    #1;
    cyc_n++;
    mul_valid_out = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        mul_valid_out = 1'b1;
        mul_product   = stub_res;
      end
    end
    if (cyc_n == spur_cycle) begin
      mul_valid_out = 1'b1;
      mul_product   = 32'hDEADBEEF;
    end
    if (mul_valid_in && !stub_hang) begin
      stub_cnt = stub_lat;
      stub_res = $signed(mul_a) * $signed(mul_b);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*W +: W]    = pa[i];
      req_b[i*W +: W]    = pb[i];
    end
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    pa[i]   = W'($urandom);
    pb[i]   = W'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
    rsp_ready = '0;
    repeat (2) cyc();
    reset = 1'b1;
    mptr  = N - 1;
    cyc();
  endtask

  // One full transaction from the IDLE cycle back to IDLE.
  task automatic do_op(input int lat, input int hold, input logic [N-1:0] after_mask);
    int g;
    int n;
    int bad;
    logic [N-1:0] oh;
    logic [W-1:0] ea, eb;
    logic [P-1:0] exp;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
    if (g < 0) return;
    oh = N'(1) << g;
    ea = pa[g];
    eb = pb[g];
    exp = $signed(ea) * $signed(eb);
    stub_lat = lat;
    #1;
    tests++;
    if (req_ready !== oh || busy !== 1'b0) begin
      fails++;
      $display("FAIL grant: req_ready=%b busy=%b, expected req_ready=%b busy=0", req_ready, busy, oh);
    end
    cyc();
    pend[g] = 1'b0;
    for (int i = 0; i < N; i++)
      if (after_mask[i] && (i == g || !pend[i])) new_req(i);
    drive_req();
    #1;
    tests++;
    if (mul_valid_in !== 1'b1 || mul_a !== ea || mul_b !== eb || req_ready !== '0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL issue: valid_in=%b a=%h b=%h req_ready=%b busy=%b, expected 1 %h %h 0000 1",
               mul_valid_in, mul_a, mul_b, req_ready, busy, ea, eb);
    end
    cyc();
    tests++;
    if (mul_valid_in !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL issue_pulse: valid_in=%b busy=%b, expected 0 1", mul_valid_in, busy);
    end
    n = 0;
    bad = 0;
    while (rsp_valid === '0 && n < 60) begin
      if (req_ready !== '0 || mul_a !== ea || mul_b !== eb) bad++;
      cyc();
      n++;
    end
    tests++;
    if (n != lat || bad != 0) begin
      fails++;
      $display("FAIL latency: wait cycles=%0d bad=%0d, expected %0d and 0", n, bad, lat);
    end
    tests++;
    if (rsp_valid !== oh || rsp_product !== exp || rsp_error !== 1'b0) begin
      fails++;
      $display("FAIL rsp: rsp_valid=%b product=%h err=%b, expected %b %h 0",
               rsp_valid, rsp_product, rsp_error, oh, exp);
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = N'($urandom) & ~oh;
      cyc();
      tests++;
      if (rsp_valid !== oh || rsp_product !== exp || req_ready !== '0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold: rsp_valid=%b product=%h req_ready=%b busy=%b, expected %b %h 0000 1",
                 rsp_valid, rsp_product, req_ready, busy, oh, exp);
      end
    end
    rsp_ready = oh | N'($urandom);
    cyc();
    rsp_ready = '0;
    mptr = g;
    tests++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL release: rsp_valid=%b busy=%b, expected 0000 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      pa[i]   = 16'h1234;
      pb[i]   = 16'h5678;
    end
    drive_req();
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_product, rsp_error, mul_a, mul_b, mul_valid_in, busy} !== '0) begin
      fails++;
      $display("FAIL reset: ready=%b rsp_valid=%b prod=%h err=%b a=%h b=%h vin=%b busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_product, rsp_error, mul_a, mul_b, mul_valid_in, busy);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    pend[1] = 1'b1;
    pa[1]   = 16'd3;
    pb[1]   = 16'hFFFB;
    drive_req();
    do_op(2, 0, '0);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) new_req(i);
    drive_req();
    for (int k = 0; k < 5; k++) do_op(int'($urandom_range(1, 4)), 0, N'(1) << ((mptr + 1) % N));
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    new_req(2);
    drive_req();
    do_op(3, 10, '1);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
    cyc();
  endtask

  task automatic test_reset_mid();
    int bad;
    apply_reset();
    new_req(3);
    drive_req();
    stub_lat = 6;
    cyc();
    pend[3] = 1'b0;
    drive_req();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_product, rsp_error, mul_a, mul_b, mul_valid_in, busy} !== '0) begin
      fails++;
      $display("FAIL reset_mid: ready=%b rsp_valid=%b prod=%h a=%h b=%h vin=%b busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_product, mul_a, mul_b, mul_valid_in, busy);
    end
    cyc();
    reset = 1'b1;
    mptr  = N - 1;
    bad = 0;
    repeat (12) begin
      cyc();
      if (rsp_valid !== '0 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: %0d bad cycles, expected 0", bad);
    end
    for (int i = 0; i < N; i++) new_req(i);
    drive_req();
    do_op(2, 1, '0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
    cyc();
  endtask

  task automatic test_spurious();
    int bad;
    bad = 0;
    spur_cycle = cyc_n + 2;
    repeat (6) begin
      cyc();
      if (busy !== 1'b0 || rsp_valid !== '0 || mul_valid_in !== 1'b0 || req_ready !== '0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL spurious: %0d bad cycles, expected 0", bad);
    end
    new_req(0);
    drive_req();
    do_op(1, 0, '0);
  endtask

  task automatic test_random();
    bit any;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= pend[i];
      if (!any) begin
        for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) new_req(i);
        new_req(int'($urandom_range(0, N - 1)));
        drive_req();
      end
      do_op(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), N'($urandom));
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    apply_reset();
    stub_hang = 1'b1;
    new_req(0);
    drive_req();
    cyc();
    pend[0] = 1'b0;
    drive_req();
    cyc();
`ifdef BOOTH_ARB_TIMEOUT_EN
    n = 0;
    bad = 0;
    while (rsp_valid === '0 && n < 60) begin
      cyc();
      n++;
    end
    tests++;
    if (n != TO) begin
      fails++;
      $display("FAIL timeout_latency: wait cycles=%0d, expected %0d", n, TO);
    end
    tests++;
    if (rsp_valid !== 4'b0001 || rsp_error !== 1'b1 || rsp_product !== '0) begin
      fails++;
      $display("FAIL timeout_rsp: rsp_valid=%b err=%b prod=%h, expected 0001 1 0",
               rsp_valid, rsp_error, rsp_product);
    end
    rsp_ready = 4'b0001;
    cyc();
    rsp_ready = '0;
    tests++;
    if (busy !== 1'b0 || bad != 0) begin
      fails++;
      $display("FAIL timeout_release: busy=%b, expected 0", busy);
    end
`else
    n = 0;
    bad = 0;
    repeat (100) begin
      cyc();
      n++;
      if (busy !== 1'b1 || rsp_valid !== '0 || rsp_error !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL no_timeout: %0d of %0d cycles not busy-waiting, expected 0", bad, n);
    end
`endif
    stub_hang = 1'b0;
    apply_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      pb[i]   = '0;
    end
    mptr = N - 1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
